// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Galois LFSR generator and its PRBS checker.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [1:LFSR_W] TAP_DEFAULT = 8'b1100_1111;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // One step of the Galois recurrence; bit 1 is the MSB, taps use the same indexing.
  function automatic logic [1:LFSR_W] lfsr8_next(input logic [1:LFSR_W] s,
                                                 input logic [1:LFSR_W] t);
    logic [1:LFSR_W] n;
    n[1] = s[LFSR_W];
    for (int k = 2; k <= LFSR_W; k++) begin
      n[k] = t[LFSR_W + 1 - k] ? (s[k-1] ^ s[LFSR_W]) : s[k-1];
    end
    return n;
  endfunction

  // Number of set bits in an 8-bit word (0..8 fits in 4 bits).
  function automatic logic [3:0] popcount8(input logic [1:LFSR_W] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 1; k <= LFSR_W; k++) begin
      c = c + {3'b000, v[k]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lfsr_prbs_checker.sv
// PRBS checker: predicts the next LFSR word, acquires lock, and counts word/bit errors.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter logic [1:LFSR_W] TAP_COEFF     = TAP_DEFAULT,
  parameter int              LOCK_THRESH   = 4,
  parameter int              UNLOCK_THRESH = 4,
  parameter int              ERR_CNT_W     = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Clear_Counters,
  input  logic                 In_Valid,
  input  logic [1:LFSR_W]      In_Data,
  output logic                 Locked,
  output logic                 Err_Pulse,
  output logic [3:0]           Err_Bits,
  output logic [ERR_CNT_W-1:0] Word_Err_Count,
  output logic [ERR_CNT_W-1:0] Bit_Err_Count
);

  localparam logic [3:0]           LOCK_T   = 4'(LOCK_THRESH);
  localparam logic [3:0]           UNLOCK_T = 4'(UNLOCK_THRESH);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  chk_state_t          state_reg, state_next;
  logic [1:LFSR_W]     pred_reg, pred_next;
  logic [3:0]          match_cnt_reg, match_cnt_next;
  logic [3:0]          miss_cnt_reg, miss_cnt_next;

  logic                err_flag;
  logic [3:0]          diff_bits;
  logic [ERR_CNT_W-1:0] word_cnt_next, bit_cnt_next;
  logic [ERR_CNT_W:0]  bit_sum;

  logic                word_match, word_zero;

  assign word_match = (In_Data == pred_reg);
  assign word_zero  = (In_Data == '0);
  assign diff_bits  = popcount8(In_Data ^ pred_reg);

  // State and predictor registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg     <= SEARCH;
      pred_reg      <= '0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pred_reg      <= pred_next;
      match_cnt_reg <= match_cnt_next;
      miss_cnt_reg  <= miss_cnt_next;
    end
  end

  // Next-state logic: seed/verify in SEARCH/VERIFY, flywheel the predictor in LOCKED.
  always_comb begin
    state_next     = state_reg;
    pred_next      = pred_reg;
    match_cnt_next = match_cnt_reg;
    miss_cnt_next  = miss_cnt_reg;
    if (In_Valid) begin
      case (state_reg)
        SEARCH: begin
          // The all-zero word is the LFSR lock-up state and can never seed a lock.
          if (!word_zero) begin
            pred_next      = lfsr8_next(In_Data, TAP_COEFF);
            match_cnt_next = '0;
            state_next     = VERIFY;
          end
        end
        VERIFY: begin
          pred_next = lfsr8_next(In_Data, TAP_COEFF);
          if (word_zero) begin
            match_cnt_next = '0;
            state_next     = SEARCH;
          end else if (word_match) begin
            if (match_cnt_reg + 4'd1 >= LOCK_T) begin
              match_cnt_next = '0;
              miss_cnt_next  = '0;
              state_next     = LOCKED;
            end else begin
              match_cnt_next = match_cnt_reg + 4'd1;
            end
          end else begin
            match_cnt_next = '0;
          end
        end
        LOCKED: begin
          // No reseeding once locked: a corrupted word must not pollute the prediction.
          pred_next = lfsr8_next(pred_reg, TAP_COEFF);
          if (word_match) begin
            miss_cnt_next = '0;
          end else if (miss_cnt_reg + 4'd1 >= UNLOCK_T) begin
            miss_cnt_next = '0;
            state_next    = SEARCH;
          end else begin
            miss_cnt_next = miss_cnt_reg + 4'd1;
          end
        end
        default: begin
          state_next = SEARCH;
        end
      endcase
    end
  end

  // Output next-values: error flag, bit count, and saturating counters (clear has priority).
  always_comb begin
    err_flag = In_Valid && (state_reg == LOCKED) && !word_match;
    bit_sum  = {1'b0, Bit_Err_Count} + (ERR_CNT_W+1)'(diff_bits);

    word_cnt_next = Word_Err_Count;
    bit_cnt_next  = Bit_Err_Count;
    if (Clear_Counters) begin
      word_cnt_next = '0;
      bit_cnt_next  = '0;
    end else if (err_flag) begin
      if (Word_Err_Count != CNT_MAX) begin
        word_cnt_next = Word_Err_Count + 1'b1;
      end
      bit_cnt_next = bit_sum[ERR_CNT_W] ? CNT_MAX : bit_sum[ERR_CNT_W-1:0];
    end
  end

  // Registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Locked         <= 1'b0;
      Err_Pulse      <= 1'b0;
      Err_Bits       <= '0;
      Word_Err_Count <= '0;
      Bit_Err_Count  <= '0;
    end else begin
      Locked         <= (state_next == LOCKED);
      Err_Pulse      <= err_flag;
      Err_Bits       <= err_flag ? diff_bits : 4'd0;
      Word_Err_Count <= word_cnt_next;
      Bit_Err_Count  <= bit_cnt_next;
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: lock, errors, loss of lock, idles, saturation, async reset.
module tb_lfsr_prbs_checker;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [1:8]  in_data;

  logic        locked, err_pulse;
  logic [3:0]  err_bits;
  logic [15:0] word_cnt, bit_cnt;

  logic        l4_locked, l4_err_pulse;
  logic [3:0]  l4_err_bits;
  logic [3:0]  l4_word_cnt, l4_bit_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-derived sequence of next() starting at 0x91 with taps 1100_1111.
  logic [7:0] seq [37] = '{
    8'h91, 8'hBB, 8'hAE, 8'h57, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'hFE, 8'h7F,
    8'hCC, 8'h66, 8'h33, 8'hEA, 8'h75, 8'hC9, 8'h97, 8'hB8, 8'h5C, 8'h2E,
    8'h17, 8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'hFC, 8'h7E, 8'h3F, 8'hEC, 8'h76,
    8'h3B, 8'hEE, 8'h77, 8'hC8, 8'h64, 8'h32, 8'h19
  };

  lfsr_prbs_checker u_dut (
    .Clock          (clock),
    .Reset          (reset),
    .Clear_Counters (clear),
    .In_Valid       (in_valid),
    .In_Data        (in_data),
    .Locked         (locked),
    .Err_Pulse      (err_pulse),
    .Err_Bits       (err_bits),
    .Word_Err_Count (word_cnt),
    .Bit_Err_Count  (bit_cnt)
  );

  lfsr_prbs_checker #(.ERR_CNT_W(4)) u_dut4 (
    .Clock          (clock),
    .Reset          (reset),
    .Clear_Counters (clear),
    .In_Valid       (in_valid),
    .In_Data        (in_data),
    .Locked         (l4_locked),
    .Err_Pulse      (l4_err_pulse),
    .Err_Bits       (l4_err_bits),
    .Word_Err_Count (l4_word_cnt),
    .Bit_Err_Count  (l4_bit_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clock);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clock);
    #1;
    $display("txn v=%0b d=%02h clr=%0b -> locked=%0b pulse=%0b bits=%0d words=%0d bitcnt=%0d",
             v, d, c, locked, err_pulse, err_bits, word_cnt, bit_cnt);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_locked",   32'(locked),    32'(0));
    check("rst_pulse",    32'(err_pulse), 32'(0));
    check("rst_bits",     32'(err_bits),  32'(0));
    check("rst_wcnt",     32'(word_cnt),  32'(0));
    check("rst_bcnt",     32'(bit_cnt),   32'(0));
    @(negedge clock);
    reset = 1'b0;

    // Zero word in SEARCH is rejected.
    step(1'b1, 8'h00, 1'b0);
    check("zero_locked", 32'(locked), 32'(0));

    // Lock acquisition: Locked rises only after the 5th word.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      check($sformatf("acq_locked_%0d", i), 32'(locked), 32'(i == 4));
    end
    check("acq_wcnt", 32'(word_cnt), 32'(0));
    check("acq_bcnt", 32'(bit_cnt),  32'(0));

    step(1'b1, seq[5], 1'b0);
    check("clean5_pulse", 32'(err_pulse), 32'(0));
    step(1'b1, seq[6], 1'b0);
    check("clean6_pulse", 32'(err_pulse), 32'(0));

    // Single-bit error.
    step(1'b1, seq[7] ^ 8'h01, 1'b0);
    check("single_pulse", 32'(err_pulse), 32'(1));
    check("single_bits",  32'(err_bits),  32'(1));
    check("single_wcnt",  32'(word_cnt),  32'(1));
    check("single_bcnt",  32'(bit_cnt),   32'(1));
    step(1'b1, seq[8], 1'b0);
    check("flywheel_pulse",  32'(err_pulse), 32'(0));
    check("flywheel_bits",   32'(err_bits),  32'(0));
    check("flywheel_locked", 32'(locked),    32'(1));
    check("flywheel_wcnt",   32'(word_cnt),  32'(1));

    // Idle gap: nothing changes, predictor holds.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h5A, 1'b0);
      check($sformatf("idle_pulse_%0d", i),  32'(err_pulse), 32'(0));
      check($sformatf("idle_locked_%0d", i), 32'(locked),    32'(1));
    end
    step(1'b1, seq[9], 1'b0);
    check("post_idle_pulse", 32'(err_pulse), 32'(0));
    check("post_idle_wcnt",  32'(word_cnt),  32'(1));

    // Clear coincident with a 2-bit error: clear wins.
    step(1'b1, seq[10] ^ 8'h03, 1'b1);
    check("clr_err_wcnt", 32'(word_cnt), 32'(0));
    check("clr_err_bcnt", 32'(bit_cnt),  32'(0));
    check("clr_err_bits", 32'(err_bits), 32'(2));
    check("clr_locked",   32'(locked),   32'(1));
    step(1'b1, seq[11], 1'b0);
    check("clr_next_pulse", 32'(err_pulse), 32'(0));

    // Loss of lock: four fully inverted words.
    for (int i = 12; i < 16; i++) begin
      step(1'b1, seq[i] ^ 8'hFF, 1'b0);
      check($sformatf("lol_bits_%0d", i),   32'(err_bits), 32'(8));
      check($sformatf("lol_locked_%0d", i), 32'(locked),   32'(i != 15));
    end
    check("lol_wcnt",    32'(word_cnt),    32'(4));
    check("lol_bcnt",    32'(bit_cnt),     32'(32));
    check("lol4_bcnt",   32'(l4_bit_cnt),  32'(15));
    check("lol4_wcnt",   32'(l4_word_cnt), 32'(4));
    check("lol4_locked", 32'(l4_locked),   32'(0));

    // Relock after 1 seed + 4 matches.
    for (int i = 16; i < 21; i++) begin
      step(1'b1, seq[i], 1'b0);
      check($sformatf("relock_%0d", i), 32'(locked), 32'(i == 20));
    end

    // Twelve errors in groups of three, each group closed by a clean word.
    for (int i = 21; i < 37; i++) begin
      logic corrupt;
      corrupt = ((i - 21) % 4) != 3;
      step(1'b1, corrupt ? (seq[i] ^ 8'hFF) : seq[i], 1'b0);
      check($sformatf("burst_pulse_%0d", i),  32'(err_pulse),    32'(corrupt));
      check($sformatf("burst_locked_%0d", i), 32'(locked),       32'(1));
      check($sformatf("burst4_bits_%0d", i),  32'(l4_err_bits),  corrupt ? 32'(8) : 32'(0));
    end
    check("sat_wcnt",  32'(word_cnt),     32'(16));
    check("sat_bcnt",  32'(bit_cnt),      32'(128));
    check("sat4_wcnt", 32'(l4_word_cnt),  32'(15));
    check("sat4_bcnt", 32'(l4_bit_cnt),   32'(15));

    // Error right before an asynchronous reset (next(0x19) = 0xFF, sent as 0xF0).
    step(1'b1, 8'hF0, 1'b0);
    check("pre_rst_pulse", 32'(err_pulse), 32'(1));
    check("pre_rst_bits",  32'(err_bits),  32'(4));
    check("pre_rst_wcnt",  32'(word_cnt),  32'(17));
    check("pre_rst_bcnt",  32'(bit_cnt),   32'(132));
    check("pre_rst4_pulse", 32'(l4_err_pulse), 32'(1));
    #2;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("arst_locked", 32'(locked),      32'(0));
    check("arst_pulse",  32'(err_pulse),   32'(0));
    check("arst_bits",   32'(err_bits),    32'(0));
    check("arst_wcnt",   32'(word_cnt),    32'(0));
    check("arst_bcnt",   32'(bit_cnt),     32'(0));
    check("arst4_wcnt",  32'(l4_word_cnt), 32'(0));
    @(negedge clock);
    reset = 1'b0;

    // After reset the checker searches again: lock after exactly 5 words.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      check($sformatf("post_rst_locked_%0d", i), 32'(locked), 32'(i == 4));
    end
    check("post_rst_wcnt", 32'(word_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
